// File: rtl/ex_mem_port_arbiter.sv
// Shares the single unified memory port between instruction fetch and the load/store stage.
// One transaction in flight, LSU-first arbitration with a starvation override for IF, response timeout.
module ex_mem_port_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_wen,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  input  logic [3:0]  ls_wstrb,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        bus_err,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_LS = 1'b1;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  // The counter value seen in the last REQ/WAIT cycle before the abort; its increment would reach TIMEOUT-1.
  localparam logic [9:0] TMO_LAST   = 10'(TIMEOUT - 2);

  logic [1:0]  state;
  logic        owner;
  logic [3:0]  starve_cnt;
  logic [9:0]  tmo_cnt;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        cmd_wen;

  logic        ls_wins;
  logic        tmo_hit;
  logic        rsp_done;
  logic        rsp_err;
  logic [31:0] rsp_data;

  assign ls_wins = ls_req && (!if_req || (starve_cnt == STARVE_LIM));
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  assign if_gnt  = !rst && (state == S_IDLE) && if_req && !ls_wins;
  assign ls_gnt  = !rst && (state == S_IDLE) && ls_wins;
  assign busy    = (state != S_IDLE);

  assign mem_wen   = cmd_wen;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign mem_wstrb = cmd_wstrb;

  // A same-cycle response always beats the timeout; the timeout beats a bare mem_gnt.
  always_comb begin
    rsp_done = 1'b0;
    rsp_err  = 1'b0;
    case (state)
      S_REQ: begin
        rsp_done = (mem_gnt && mem_rvalid) || tmo_hit;
        rsp_err  = !(mem_gnt && mem_rvalid) && tmo_hit;
      end
      S_WAIT: begin
        rsp_done = mem_rvalid || tmo_hit;
        rsp_err  = !mem_rvalid && tmo_hit;
      end
      default: begin
        rsp_done = 1'b0;
        rsp_err  = 1'b0;
      end
    endcase
    rsp_data = (rsp_err || ((owner == OWN_LS) && cmd_wen)) ? 32'h0 : mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= OWN_IF;
      starve_cnt <= 4'd0;
      tmo_cnt    <= 10'd0;
      cmd_addr   <= 32'h0;
      cmd_wdata  <= 32'h0;
      cmd_wstrb  <= 4'h0;
      cmd_wen    <= 1'b0;
      mem_req    <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= 32'h0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= 32'h0;
      bus_err    <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (if_req || ls_req) begin
            state   <= S_REQ;
            mem_req <= 1'b1;
            tmo_cnt <= 10'd0;
            owner   <= ls_wins ? OWN_LS : OWN_IF;
            if (ls_wins) begin
              cmd_addr  <= ls_addr;
              cmd_wen   <= ls_wen;
              cmd_wdata <= ls_wdata;
              cmd_wstrb <= ls_wstrb;
            end else begin
              cmd_addr  <= if_addr;
              cmd_wen   <= 1'b0;
              cmd_wdata <= 32'h0;
              cmd_wstrb <= 4'hF;
            end
            if (!ls_wins) begin
              starve_cnt <= 4'd0;
            end else if (if_req && (starve_cnt != STARVE_LIM)) begin
              starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        S_REQ, S_WAIT: begin
          tmo_cnt <= tmo_cnt + 10'd1;
          if (rsp_done) begin
            state   <= S_RESP;
            mem_req <= 1'b0;
            bus_err <= rsp_err;
            if (owner == OWN_LS) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= rsp_data;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= rsp_data;
            end
          end else if ((state == S_REQ) && mem_gnt) begin
            state   <= S_WAIT;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_mem_port_arbiter.sv
// Self-checking bench for ex_mem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration, latency, timeout and response data.
module tb_ex_mem_port_arbiter;

  localparam int STARVE_MAX = 2;
  localparam int TIMEOUT    = 8;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_wen;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [3:0]  ls_wstrb;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        bus_err;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  int          gl_cfg;
  int          rl_cfg;
  bit          ng_cfg;
  int          m_starve;
  logic [31:0] last_if_rd;
  logic [31:0] last_ls_rd;

  ex_mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_wen(ls_wen), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] memData(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0013;
    if (a == 32'h0000_0200) return 32'h1234_5678;
    return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
  endfunction

  function automatic logic [159:0] allOut();
    return {if_gnt, if_rvalid, if_rdata, ls_gnt, ls_rvalid, ls_rdata, mem_req, mem_wen,
            mem_addr, mem_wdata, mem_wstrb, bus_err, busy};
  endfunction

  // Memory side: grant after gl_cfg REQ cycles, respond rl_cfg cycles after the grant (0 = same cycle).
  initial begin
    bit          pend;
    int          rcnt;
    int          age;
    logic [31:0] paddr;
    pend = 0; rcnt = 0; age = 0; paddr = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (pend) begin
        rcnt--;
        if (rcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memData(paddr);
          pend       = 0;
        end
      end else if (mem_req && !ng_cfg) begin
        if (age == gl_cfg) begin
          mem_gnt = 1'b1;
          paddr   = mem_addr;
          if (rl_cfg == 0) begin
            mem_rvalid = 1'b1;
            mem_rdata  = memData(mem_addr);
          end else begin
            pend = 1;
            rcnt = rl_cfg;
          end
        end else begin
          age++;
        end
      end
      if (!mem_req) age = 0;
    end
  end

  task automatic checkOutput(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit set_if, input logic [31:0] ia, input bit set_ls,
                               input logic lw, input logic [31:0] la, input logic [31:0] ld,
                               input logic [3:0] lstrb);
    if (set_if) begin
      if_req  = 1'b1;
      if_addr = ia;
    end
    if (set_ls) begin
      ls_req   = 1'b1;
      ls_wen   = lw;
      ls_addr  = la;
      ls_wdata = ld;
      ls_wstrb = lstrb;
    end
  endtask

  task automatic setMem(input int gl, input int rl, input bit ng);
    gl_cfg = gl;
    rl_cfg = rl;
    ng_cfg = ng;
  endtask

  // Called at a negedge with the arbiter idle and requests already applied; runs one grant to completion.
  task automatic transact(input string tag);
    bit          exp_ls;
    bit          eerr;
    bit          got;
    logic [31:0] ea, ewd, erd;
    logic [3:0]  ews;
    logic        ewen;
    int          gle, elat, ereq, lat, reqc;
    exp_ls = ls_req && (!if_req || (m_starve == STARVE_MAX));
    if (if_req && ls_req) m_starve = exp_ls ? m_starve + 1 : 0;
    else if (if_req)      m_starve = 0;
    ea   = exp_ls ? ls_addr  : if_addr;
    ewen = exp_ls ? ls_wen   : 1'b0;
    ews  = exp_ls ? ls_wstrb : 4'hF;
    ewd  = exp_ls ? ls_wdata : 32'h0;
    gle  = ng_cfg ? 1000 : gl_cfg;
    eerr = (gle + rl_cfg) > (TIMEOUT - 2);
    elat = eerr ? TIMEOUT : gle + rl_cfg + 2;
    ereq = (gle + 1 < TIMEOUT - 1) ? gle + 1 : TIMEOUT - 1;
    erd  = (eerr || ewen) ? 32'h0 : memData(ea);
    #1;
    checkOutput({tag, "/gnt"}, {if_gnt, ls_gnt}, exp_ls ? 2'b01 : 2'b10);
    lat = 0; reqc = 0; got = 0;
    while (!got && lat < TIMEOUT + 4) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (exp_ls) ls_req = 1'b0;
        else        if_req = 1'b0;
        checkOutput({tag, "/cmd"}, {mem_req, busy, mem_wen, mem_wstrb, mem_addr, mem_wdata},
                    {2'b11, ewen, ews, ea, ewd});
      end
      if (mem_req) reqc++;
      got = if_rvalid || ls_rvalid;
    end
    checkOutput({tag, "/latency"}, lat, elat);
    checkOutput({tag, "/req_cycles"}, reqc, ereq);
    checkOutput({tag, "/rvalid_err"}, {if_rvalid, ls_rvalid, bus_err}, {!exp_ls, exp_ls, eerr});
    if (exp_ls) last_ls_rd = erd;
    else        last_if_rd = erd;
    checkOutput({tag, "/rdata"}, {if_rdata, ls_rdata}, {last_if_rd, last_ls_rd});
    @(negedge clk);
    checkOutput({tag, "/idle"}, {if_rvalid, ls_rvalid, bus_err, busy}, 4'b0000);
  endtask

  initial begin
    int rv_seen;
    rst = 1'b1;
    if_req = 1'b0; if_addr = 32'h0;
    ls_req = 1'b0; ls_wen = 1'b0; ls_addr = 32'h0; ls_wdata = 32'h0; ls_wstrb = 4'h0;
    m_starve = 0; last_if_rd = 32'h0; last_ls_rd = 32'h0;
    setMem(0, 0, 0);
    repeat (2) @(negedge clk);
    checkOutput("reset/outputs", allOut(), '0);
    rst = 1'b0;
    $display("[TB] reset released");

    setMem(0, 1, 0);
    applyStimulus(1, 32'h8000_0000, 0, 1'b0, 32'h0, 32'h0, 4'h0);
    transact("fetch_alone");

    setMem(0, 0, 0);
    applyStimulus(1, 32'h8000_0004, 1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'h3);
    transact("both_ls_store");
    transact("both_if_next");

    applyStimulus(0, 32'h0, 1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
    transact("same_cycle_load");

    for (int i = 0; i < 6; i++) begin
      if (!if_req) applyStimulus(1, 32'h8000_1000 + 32'(i * 4), 0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (!ls_req) applyStimulus(0, 32'h0, 1, 1'b0, 32'h0000_0400 + 32'(i * 4), 32'h0, 4'hF);
      transact($sformatf("starve_%0d", i));
    end

    setMem(0, 0, 1);
    transact("timeout_nognt");
    setMem(0, 1, 0);
    applyStimulus(1, 32'h8000_0020, 0, 1'b0, 32'h0, 32'h0, 4'h0);
    transact("after_timeout");

    setMem(TIMEOUT - 2, 1, 0);
    applyStimulus(1, 32'h8000_0100, 0, 1'b0, 32'h0, 32'h0, 4'h0);
    transact("tmo_beats_gnt");
    setMem(TIMEOUT - 2, 0, 0);
    applyStimulus(0, 32'h0, 1, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 4'hC);
    transact("rvalid_at_last_cycle");

    setMem(0, 6, 0);
    applyStimulus(1, 32'h8000_0040, 0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    checkOutput("rst_wait/gnt", {if_gnt, ls_gnt}, 2'b10);
    @(negedge clk);
    if_req = 1'b0;
    checkOutput("rst_wait/req", mem_req, 1'b1);
    @(negedge clk);
    checkOutput("rst_wait/in_wait", {mem_req, busy}, 2'b01);
    rst = 1'b1;
    #1;
    checkOutput("rst_wait/outputs", allOut(), '0);
    @(negedge clk);
    rst = 1'b0;
    m_starve = 0; last_if_rd = 32'h0; last_ls_rd = 32'h0;
    rv_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (if_rvalid || ls_rvalid || bus_err || busy) rv_seen++;
    end
    checkOutput("rst_wait/stale_ignored", rv_seen, 0);
    setMem(0, 1, 0);
    applyStimulus(1, 32'h8000_0000, 0, 1'b0, 32'h0, 32'h0, 4'h0);
    transact("fetch_after_rst");

    for (int t = 0; t < 60; t++) begin
      if (!if_req && ($urandom_range(0, 1) == 1))
        applyStimulus(1, $urandom() & 32'hFFFF_FFFC, 0, 1'b0, 32'h0, 32'h0, 4'h0);
      if (!ls_req && (($urandom_range(0, 1) == 1) || !if_req))
        applyStimulus(0, 32'h0, 1, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC,
                      $urandom(), 4'($urandom_range(0, 15)));
      setMem($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 9) == 0);
      transact($sformatf("rnd_%0d", t));
    end
    if_req = 1'b0;
    ls_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ex_mem_port_arbiter.md
Name: ex_mem_port_arbiter

Overview:
- Sequences and shares the single unified memory port between instruction fetch (IF) and the load/store stage (LSWB, fed by EX results: address from Ex_result, store data from rs2_value).
- One outstanding transaction at a time.
- Fixed LSU priority with an anti-starvation override for IF, plus a response timeout.
- Sits between IF/LSWB stages and the memory model/bus.

Parameters:
- STARVE_MAX, 4: consecutive IF losses before IF is forced to win (legal range 1..15).
- TIMEOUT, 64: cycles in REQ+WAIT before the transaction is aborted (legal range 2..1023).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch address.
- if_gnt  out  1  one-cycle pulse: fetch request latched.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  32  fetched instruction.
- ls_req  in  1  load/store request; held until ls_gnt.
- ls_wen  in  1  1 = store, 0 = load.
- ls_addr  in  32  data address.
- ls_wdata  in  32  store data.
- ls_wstrb  in  4  byte enables.
- ls_gnt  out  1  one-cycle pulse: LS request latched.
- ls_rvalid  out  1  one-cycle pulse: load data valid or store done.
- ls_rdata  out  32  load data (0 for stores).
- mem_req  out  1  memory request.
- mem_wen  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_wstrb  out  4  memory byte enables; 4'hF for fetch.
- mem_gnt  in  1  memory accepted request.
- mem_rvalid  in  1  memory response; acks writes too.
- mem_rdata  in  32  memory read data.
- bus_err  out  1  one-cycle pulse with the rvalid of a timed-out transaction.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, owner=IF, starve_cnt=0, tmo_cnt=0, command registers 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - If ls_req or if_req: pick the winner, latch its addr/wdata/wstrb/wen into command registers, pulse the winner's gnt this cycle, go to REQ.
  - Winner rule: ls_req alone -> LS; if_req alone -> IF; both -> LS, unless starve_cnt==STARVE_MAX, then IF.
  - starve_cnt: +1 when both request and LS wins; cleared when IF wins; saturates at STARVE_MAX.
  - mem_rvalid in IDLE is ignored (stale response after reset).
- REQ:
  - mem_req=1; mem_* driven from command registers; IF transactions drive mem_wen=0, mem_wstrb=4'hF, mem_wdata=0.
  - On mem_gnt: drop mem_req next cycle. Go to WAIT, or straight to RESP if mem_rvalid is also high that cycle (rdata captured).
- WAIT: mem_req=0. On mem_rvalid, capture mem_rdata and go to RESP.
- RESP (one cycle):
  - Pulse the owner's rvalid with the captured data. ls_rdata is forced to 0 for stores.
  - Non-owner rvalid stays 0; rdata outputs hold their last value.
  - Return to IDLE; new arbitration happens in the following IDLE cycle.
- Minimum latency: gnt in cycle N, rvalid in cycle N+2 (mem_gnt and mem_rvalid both in N+1). Back-to-back grants are 3 cycles apart at best.
- Timeout:
  - tmo_cnt clears on IDLE->REQ and increments each cycle in REQ/WAIT.
  - When it reaches TIMEOUT-1 without completion: go to RESP with rdata=0, pulse bus_err with the owner's rvalid, and drop mem_req.
  - Timeout takes precedence over a mem_gnt in the same cycle; mem_rvalid in that same cycle completes normally (no error).
  - A late response is ignored in IDLE; the memory side must not return it after a new mem_req is accepted.
- Requesters:
  - May drop req before gnt with no effect.
  - Must hold address/data stable while req=1 and gnt=0.
  - Must not re-request before their rvalid.
- The registered mem_* outputs are glitch-free; no combinational path from if_req/ls_req to mem_*.
- No combinational path from mem_rvalid to if_rvalid/ls_rvalid; responses are registered.

Test Plan:
- Fetch alone:
  - Stimulus: if_req, if_addr=0x80000000; memory gnt in +1 cycle, rvalid in +2 cycles, rdata=0x00000013.
  - Response: if_gnt at N; mem_addr=0x80000000, mem_wstrb=F; if_rvalid with if_rdata=0x00000013 at N+3.
- Simultaneous if_req and ls_req:
  - Stimulus: ls_wen=1, ls_addr=0x100, ls_wdata=0xDEADBEEF, ls_wstrb=0x3; zero-wait memory.
  - Response: LS granted first, mem_wdata=0xDEADBEEF, mem_wstrb=3; ls_rvalid with ls_rdata=0; IF granted next.
- Starvation, STARVE_MAX=2:
  - Stimulus: both requesters assert continuously.
  - Response: grant order LS, LS, IF, LS, LS, IF; starve_cnt back to 0 after each IF grant.
- Timeout, TIMEOUT=8:
  - Stimulus: memory never asserts mem_gnt.
  - Response: mem_req held 7 cycles; owner rvalid and bus_err pulse together, rdata=0; next request is served normally.
- Reset in WAIT:
  - Stimulus: assert rst mid-transaction; memory later sends a stale mem_rvalid in IDLE.
  - Response: all outputs 0 immediately; no rvalid is delivered; a subsequent fetch completes normally.
- Same-cycle mem_gnt and mem_rvalid on a load:
  - Stimulus: load from 0x200, mem_rdata=0x12345678.
  - Response: REQ->RESP directly; ls_rvalid 2 cycles after ls_gnt with ls_rdata=0x12345678.
